// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EX/MEM pipeline registers and the
// central pipeline controller. The pipeline side (master) presents register
// fields and the debug halt request; the controller (slave) returns enables,
// flushes, comparator forwarding selects and event counters.
interface pipeline_hazard_ctrl_if;
  logic [2:0]  id_rs1;
  logic [2:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_is_branch;
  logic        id_jump;
  logic [2:0]  ex_rd;
  logic [2:0]  mem_rd;
  logic        ex_regwrite;
  logic        mem_regwrite;
  logic        ex_memread;
  logic        mem_memread;
  logic        halt_req;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        comparatorMux1Control;
  logic        comparatorMux2Control;
  logic        halt_ack;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch, id_jump,
           ex_rd, mem_rd, ex_regwrite, mem_regwrite, ex_memread, mem_memread,
           halt_req,
    input  pc_write, ifid_write, ifid_flush, idex_flush,
           comparatorMux1Control, comparatorMux2Control, halt_ack,
           stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_is_branch, id_jump,
           ex_rd, mem_rd, ex_regwrite, mem_regwrite, ex_memread, mem_memread,
           halt_req,
    output pc_write, ifid_write, ifid_flush, idex_flush,
           comparatorMux1Control, comparatorMux2Control, halt_ack,
           stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 16-bit five-stage core. Detects load-use
// and early-branch hazards, selects decode-comparator forwarding from MEM,
// drives PC/IF-ID enables and flushes, sequences a debug halt that drains the
// pipeline, and keeps saturating stall/flush event counters.
module pipeline_hazard_ctrl (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  drain_cnt;
  logic [1:0]  next_drain_cnt;

  logic        m1_ex;
  logic        m2_ex;
  logic        m1_mem;
  logic        m2_mem;
  logic        ex_hit;
  logic        mem_hit;
  logic        stall;
  logic        fwd1;
  logic        fwd2;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mux1_sel;
  logic        mux2_sel;
  logic        halt_ack;
  logic        stall_evt;
  logic        flush_evt;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  // Source-register matches against the EX and MEM destinations.
  assign m1_ex   = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
  assign m2_ex   = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);
  assign m1_mem  = bus.id_uses_rs1 && (bus.id_rs1 == bus.mem_rd);
  assign m2_mem  = bus.id_uses_rs2 && (bus.id_rs2 == bus.mem_rd);
  assign ex_hit  = m1_ex || m2_ex;
  assign mem_hit = m1_mem || m2_mem;

  // A load in EX blocks any consumer; a branch compares in ID so it also waits
  // on an ALU result still in EX and on a load still in MEM.
  assign stall = (bus.ex_memread && bus.ex_regwrite && ex_hit) ||
                 (bus.id_is_branch && bus.ex_regwrite && ex_hit) ||
                 (bus.id_is_branch && bus.mem_memread && bus.mem_regwrite && mem_hit);

  // MEM ALU results feed the comparator unless a younger EX write to the same
  // register exists (that case is a stall, and the MEM value would be stale).
  assign fwd1 = bus.id_is_branch && bus.mem_regwrite && !bus.mem_memread &&
                m1_mem && !(bus.ex_regwrite && m1_ex);
  assign fwd2 = bus.id_is_branch && bus.mem_regwrite && !bus.mem_memread &&
                m2_mem && !(bus.ex_regwrite && m2_ex);

  // State and drain counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      drain_cnt <= 2'd0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_drain_cnt;
    end
  end

  // Next-state and pipeline control outputs; the frozen (BOOT/HALTED) values are the defaults.
  always_comb begin
    next_state     = state;
    next_drain_cnt = drain_cnt;
    pc_write       = 1'b0;
    ifid_write     = 1'b0;
    ifid_flush     = 1'b1;
    idex_flush     = 1'b1;
    mux1_sel       = 1'b0;
    mux2_sel       = 1'b0;
    halt_ack       = 1'b0;
    stall_evt      = 1'b0;
    flush_evt      = 1'b0;
    case (state)
      BOOT: begin
        next_state = RUN;
      end
      RUN: begin
        mux1_sel = fwd1;
        mux2_sel = fwd2;
        if (stall) begin
          ifid_flush = 1'b0;
          stall_evt  = 1'b1;
        end else begin
          ifid_write = 1'b1;
          idex_flush = 1'b0;
          if (bus.id_jump) begin
            pc_write  = 1'b1;
            flush_evt = 1'b1;
          end else if (bus.halt_req) begin
            next_state     = DRAIN;
            next_drain_cnt = 2'd3;
          end else begin
            pc_write   = 1'b1;
            ifid_flush = 1'b0;
          end
        end
      end
      DRAIN: begin
        ifid_write     = 1'b1;
        idex_flush     = 1'b0;
        next_drain_cnt = drain_cnt - 2'd1;
        if (drain_cnt == 2'd1) begin
          next_state = HALTED;
        end
      end
      HALTED: begin
        halt_ack = 1'b1;
        if (!bus.halt_req) begin
          next_state = RUN;
        end
      end
      default: begin
        next_state = BOOT;
      end
    endcase
  end

  // Saturating event counters for stalls and jump-induced IF/ID flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (stall_evt && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (flush_evt && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end

  assign bus.pc_write              = pc_write;
  assign bus.ifid_write            = ifid_write;
  assign bus.ifid_flush            = ifid_flush;
  assign bus.idex_flush            = idex_flush;
  assign bus.comparatorMux1Control = mux1_sel;
  assign bus.comparatorMux2Control = mux2_sel;
  assign bus.halt_ack              = halt_ack;
  assign bus.stall_count           = stall_count;
  assign bus.flush_count           = flush_count;

endmodule
